// File: rtl/run_ctrl.sv
// Run controller for the X9 core: host preload, core execution, halt/timeout detection
// and completion handshake. Owns the single data-memory write port.
module run_ctrl #(
    parameter int unsigned D       = 12,
    parameter int unsigned AW      = 8,
    parameter int unsigned DW      = 8,
    parameter int unsigned HALT_PC = 128,
    parameter int unsigned TMO     = 4000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    input  logic          host_valid,
    input  logic          host_last,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_data,
    output logic          host_ready,
    input  logic [D-1:0]  prog_ctr,
    input  logic          core_wr_en,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_dat,
    output logic          core_rst,
    output logic          mem_wr_en,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_dat,
    output logic          done,
    output logic          timeout,
    output logic [15:0]   cycles
);

    typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

    localparam logic [D-1:0] HaltPc  = D'(HALT_PC);
    localparam logic [15:0]  TmoLast = 16'(TMO - 1);

    state_e      state_q, state_d;
    logic [15:0] cycles_q, cycles_d;
    logic        timeout_q, timeout_d;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= StIdle;
            cycles_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cycles_q  <= cycles_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cycles_d  = cycles_q;
        timeout_d = timeout_q;
        case (state_q)
            StIdle: begin
                if (req) begin
                    state_d   = StLoad;
                    cycles_d  = '0;
                    timeout_d = 1'b0;
                end
            end
            StLoad: begin
                if (host_valid && host_last) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (cycles_q != 16'hFFFF) begin
                    cycles_d = cycles_q + 16'd1;
                end
                // Halt takes priority over a coincident timeout.
                if (prog_ctr == HaltPc) begin
                    state_d   = StDone;
                    timeout_d = 1'b0;
                end else if (cycles_q == TmoLast) begin
                    state_d   = StDone;
                    timeout_d = 1'b1;
                end
            end
            StDone: begin
                if (!req) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Memory port mux: host in LOAD, core in RUN, idle otherwise.
    always_comb begin
        mem_wr_en = 1'b0;
        mem_addr  = '0;
        mem_dat   = '0;
        if (state_q == StLoad) begin
            mem_wr_en = host_valid;
            mem_addr  = host_addr;
            mem_dat   = host_data;
        end else if (state_q == StRun) begin
            mem_wr_en = core_wr_en;
            mem_addr  = core_addr;
            mem_dat   = core_dat;
        end
    end

    assign host_ready = (state_q == StLoad);
    assign core_rst   = (state_q != StRun);
    assign done       = (state_q == StDone);
    assign timeout    = timeout_q;
    assign cycles     = cycles_q;

endmodule

// File: tb/tb_run_ctrl.sv
// Directed bench for run_ctrl: a default-timeout instance (a_*) and a TMO=20 instance (b_*)
// share all inputs so halt, timeout and coincident cases are observable in one run.
module tb_run_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       req;
    logic       host_valid, host_last;
    logic [7:0] host_addr, host_data;
    logic [11:0] prog_ctr;
    logic       core_wr_en;
    logic [7:0] core_addr, core_dat;

    logic        a_host_ready, a_core_rst, a_mem_wr_en, a_done, a_timeout;
    logic [7:0]  a_mem_addr, a_mem_dat;
    logic [15:0] a_cycles;
    logic        b_host_ready, b_core_rst, b_mem_wr_en, b_done, b_timeout;
    logic [7:0]  b_mem_addr, b_mem_dat;
    logic [15:0] b_cycles;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    run_ctrl #(.D(12), .AW(8), .DW(8), .HALT_PC(128), .TMO(4000)) dut_a (
        .clk(clk), .reset(reset), .req(req),
        .host_valid(host_valid), .host_last(host_last), .host_addr(host_addr),
        .host_data(host_data), .host_ready(a_host_ready),
        .prog_ctr(prog_ctr), .core_wr_en(core_wr_en), .core_addr(core_addr),
        .core_dat(core_dat), .core_rst(a_core_rst),
        .mem_wr_en(a_mem_wr_en), .mem_addr(a_mem_addr), .mem_dat(a_mem_dat),
        .done(a_done), .timeout(a_timeout), .cycles(a_cycles)
    );

    run_ctrl #(.D(12), .AW(8), .DW(8), .HALT_PC(128), .TMO(20)) dut_b (
        .clk(clk), .reset(reset), .req(req),
        .host_valid(host_valid), .host_last(host_last), .host_addr(host_addr),
        .host_data(host_data), .host_ready(b_host_ready),
        .prog_ctr(prog_ctr), .core_wr_en(core_wr_en), .core_addr(core_addr),
        .core_dat(core_dat), .core_rst(b_core_rst),
        .mem_wr_en(b_mem_wr_en), .mem_addr(b_mem_addr), .mem_dat(b_mem_dat),
        .done(b_done), .timeout(b_timeout), .cycles(b_cycles)
    );

    typedef struct {
        logic       valid;
        logic       last;
        logic [7:0] addr;
        logic [7:0] data;
        logic       exp_wr;
    } load_vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        load_vec_t lv[5];
        int        pulses;

        lv[0] = '{valid: 1'b1, last: 1'b0, addr: 8'h00, data: 8'h11, exp_wr: 1'b1};
        lv[1] = '{valid: 1'b0, last: 1'b0, addr: 8'h7F, data: 8'hEE, exp_wr: 1'b0};
        lv[2] = '{valid: 1'b1, last: 1'b0, addr: 8'h01, data: 8'h22, exp_wr: 1'b1};
        lv[3] = '{valid: 1'b0, last: 1'b1, addr: 8'h7E, data: 8'hDD, exp_wr: 1'b0};
        lv[4] = '{valid: 1'b1, last: 1'b1, addr: 8'h02, data: 8'h33, exp_wr: 1'b1};

        reset = 1'b0; req = 1'b1;
        host_valid = 1'b1; host_last = 1'b0; host_addr = 8'h55; host_data = 8'h66;
        prog_ctr = '0; core_wr_en = 1'b0; core_addr = '0; core_dat = '0;

        // Reset held with req=1
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_core_rst", 32'(a_core_rst), 32'd1);
            check("rst_done", 32'(a_done), 32'd0);
            check("rst_cycles", 32'(a_cycles), 32'd0);
            check("rst_host_ready", 32'(a_host_ready), 32'd0);
            check("rst_mem_wr_en", 32'(a_mem_wr_en), 32'd0);
            check("rst_mem_addr", 32'(a_mem_addr), 32'd0);
            check("rst_timeout", 32'(a_timeout), 32'd0);
        end
        reset = 1'b1;
        #1;
        check("idle_after_release_ready", 32'(a_host_ready), 32'd0);
        check("idle_host_not_written", 32'(a_mem_wr_en), 32'd0);
        tick();
        check("load_entered_ready", 32'(a_host_ready), 32'd1);
        check("load_core_rst", 32'(a_core_rst), 32'd1);

        // Host load with gaps and a stray host_last
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            host_valid = lv[i].valid; host_last = lv[i].last;
            host_addr = lv[i].addr; host_data = lv[i].data;
            #1;
            check($sformatf("load%0d_wr", i), 32'(a_mem_wr_en), 32'(lv[i].exp_wr));
            check($sformatf("load%0d_addr", i), 32'(a_mem_addr), 32'(lv[i].addr));
            check($sformatf("load%0d_dat", i), 32'(a_mem_dat), 32'(lv[i].data));
            check($sformatf("load%0d_ready", i), 32'(a_host_ready), 32'd1);
            if (a_mem_wr_en) pulses++;
            tick();
        end
        check("load_pulses", 32'(pulses), 32'd3);
        host_valid = 1'b0; host_last = 1'b0;
        check("run_entered_core_rst", 32'(a_core_rst), 32'd0);
        check("run_entered_ready", 32'(a_host_ready), 32'd0);

        // RUN with PC stepping to HALT_PC; core write at cycle 10, stray host beat at 3
        for (int k = 0; k <= 128; k++) begin
            prog_ctr = 12'(k);
            core_wr_en = (k == 10); core_addr = 8'h40; core_dat = 8'hA5;
            host_valid = (k == 3); host_addr = 8'h99; host_data = 8'h77;
            #1;
            check($sformatf("run%0d_wr", k), 32'(a_mem_wr_en), 32'(k == 10));
            if (k == 10) begin
                check("run_core_addr", 32'(a_mem_addr), 32'h40);
                check("run_core_dat", 32'(a_mem_dat), 32'hA5);
            end
            check($sformatf("run%0d_core_rst", k), 32'(a_core_rst), 32'd0);
            check($sformatf("run%0d_done", k), 32'(a_done), 32'd0);
            tick();
        end
        host_valid = 1'b0;
        check("halt_done", 32'(a_done), 32'd1);
        check("halt_cycles", 32'(a_cycles), 32'd129);
        check("halt_timeout", 32'(a_timeout), 32'd0);
        check("halt_core_rst", 32'(a_core_rst), 32'd1);
        check("b_step_done", 32'(b_done), 32'd1);
        check("b_step_timeout", 32'(b_timeout), 32'd1);
        check("b_step_cycles", 32'(b_cycles), 32'd20);
        core_wr_en = 1'b1;
        #1;
        check("done_core_write_dropped", 32'(a_mem_wr_en), 32'd0);
        core_wr_en = 1'b0;
        tick(); tick();
        check("done_hold_req", 32'(a_done), 32'd1);
        check("done_cycles_hold", 32'(a_cycles), 32'd129);
        req = 1'b0;
        tick();
        check("done_drop_a", 32'(a_done), 32'd0);
        check("done_drop_b", 32'(b_done), 32'd0);
        check("idle_core_rst", 32'(a_core_rst), 32'd1);

        // Timeout: PC stuck at 5 on the TMO=20 instance
        req = 1'b1;
        tick();
        check("clr_cycles", 32'(b_cycles), 32'd0);
        check("clr_timeout", 32'(b_timeout), 32'd0);
        host_valid = 1'b1; host_last = 1'b1; host_addr = 8'h00; host_data = 8'h00;
        tick();
        host_valid = 1'b0; host_last = 1'b0; prog_ctr = 12'd5;
        repeat (19) tick();
        check("tmo_not_yet_done", 32'(b_done), 32'd0);
        check("tmo_cycles19", 32'(b_cycles), 32'd19);
        tick();
        check("tmo_done", 32'(b_done), 32'd1);
        check("tmo_timeout", 32'(b_timeout), 32'd1);
        check("tmo_cycles", 32'(b_cycles), 32'd20);
        check("tmo_core_rst", 32'(b_core_rst), 32'd1);
        tick();
        check("tmo_cycles_hold", 32'(b_cycles), 32'd20);

        // Reset mid-RUN on the default instance while the core writes
        core_wr_en = 1'b1; core_addr = 8'h12; core_dat = 8'h34; reset = 1'b0;
        #1;
        check("pre_reset_core_write", 32'(a_mem_wr_en), 32'd1);
        tick();
        check("mid_rst_wr", 32'(a_mem_wr_en), 32'd0);
        check("mid_rst_core_rst", 32'(a_core_rst), 32'd1);
        check("mid_rst_cycles", 32'(a_cycles), 32'd0);
        check("mid_rst_addr", 32'(a_mem_addr), 32'd0);
        check("mid_rst_b_done", 32'(b_done), 32'd0);
        check("mid_rst_b_timeout", 32'(b_timeout), 32'd0);
        tick();
        check("mid_rst_wr2", 32'(a_mem_wr_en), 32'd0);
        reset = 1'b1; core_wr_en = 1'b0; req = 1'b0;
        tick();
        check("post_rst_idle", 32'(a_host_ready), 32'd0);

        // Halt coincides with the last allowed cycle on the TMO=20 instance
        req = 1'b1;
        tick();
        host_valid = 1'b1; host_last = 1'b1;
        tick();
        host_valid = 1'b0; host_last = 1'b0; prog_ctr = 12'd0;
        repeat (19) tick();
        check("tie_not_yet_done", 32'(b_done), 32'd0);
        prog_ctr = 12'd128;
        tick();
        check("tie_done", 32'(b_done), 32'd1);
        check("tie_timeout", 32'(b_timeout), 32'd0);
        check("tie_cycles", 32'(b_cycles), 32'd20);
        check("tie_a_done", 32'(a_done), 32'd1);
        req = 1'b0;
        tick();
        check("tie_drop_done", 32'(b_done), 32'd0);
        check("tie_idle_ready", 32'(b_host_ready), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
